measurement_sampler: RTL and testbench
======================================

MEASUREMENT_SAMPLER -- requirements
Module: measurement_sampler

Interface
REQ-001 Parameter NQ, default 2: qubit count; the block holds NS = 2^NQ basis states.
REQ-002 Parameter AW, default 16: amplitude width, signed Q2.(AW-2), so 1.0 = 2^(AW-2).
REQ-003 Parameter CW, default 16: width of each histogram counter.
REQ-004 Parameter SEED, default 32'h1: initial RNG state; a value of 0 SHALL be replaced by 1.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 amp_re  in  NS*AW  real parts, flattened; state k occupies bits [k*AW +: AW].
REQ-008 amp_im  in  NS*AW  imaginary parts, same packing as amp_re.
REQ-009 start  in  1  begin a measurement run; sampled only in IDLE.
REQ-010 shots  in  CW  number of samples; latched together with start.
REQ-011 busy  out  1  high in LOAD and SAMPLE.
REQ-012 done  out  1  one-cycle pulse at the end of a run.
REQ-013 hist  out  NS*CW  per-state outcome counts, flattened.
REQ-014 miss  out  CW  count of samples that hit no state.
REQ-015 sample_valid  out  1  one-cycle pulse per drawn sample.
REQ-016 sample_idx  out  NQ  state index of the current sample; all-ones on a miss.

Function
REQ-017 The state machine SHALL have four states, IDLE, LOAD, SAMPLE and DONE, with these transitions:
  - IDLE to LOAD on start=1;
  - LOAD to SAMPLE after NS cycles;
  - SAMPLE to DONE after the latched shots count of cycles;
  - DONE to IDLE after 1 cycle.
REQ-018 The edge that accepts start SHALL:
  - latch shots and both amplitude buses;
  - clear hist, miss and the cumulative table.
REQ-019 LOAD SHALL compute one state per cycle, k = 0..NS-1:
  - p_k = (re_k^2 + im_k^2) >> (2*(AW-2)-16), unsigned 17 bits, so 1.0 = 65536;
  - cum_k = cum_(k-1) + p_k, held in 17+NQ bits without overflow.
REQ-020 The RNG SHALL be a 32-bit xorshift (shifts 13, 17, 5) that advances only on SAMPLE cycles; r = state[15:0].
REQ-021 Each SAMPLE cycle SHALL select the smallest k with r < cum_k, then increment hist[k] and pulse sample_valid with sample_idx = k.
REQ-022 If r >= cum_(NS-1), the sample SHALL increment miss and report sample_idx = all-ones.
REQ-023 hist and miss counters SHALL saturate at 2^CW-1 and never wrap.
REQ-024 shots = 0 SHALL run LOAD, go directly to DONE, and leave hist and miss at zero.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 Amplitude changes after acceptance SHALL have no effect on the run.
REQ-027 done SHALL be high only in DONE.
REQ-028 Start-to-done latency SHALL be exactly NS + shots + 1 clock edges after the accepting edge.
REQ-029 hist and miss SHALL hold their values after DONE until the next accepted start.

Reset
REQ-030 reset=0 SHALL immediately force IDLE and zero busy, done, hist, miss, sample_valid and sample_idx, and load the RNG with SEED.
REQ-031 reset asserted mid-run SHALL abort the run with no done pulse.
REQ-032 Operation SHALL resume on the first rising edge of clk after reset is released.

Verification
REQ-033 Basis state: NQ=2; amp00_re=16'h4000, all other amplitudes 0; shots=100.
  - hist = {100,0,0,0}, miss=0;
  - done exactly 105 edges after start.
REQ-034 Bell state: amp00_re = amp11_re = 16'h2D41 (p=32766 each); shots=1000.
  - hist1 = hist2 = 0;
  - hist0 + hist3 + miss = 1000;
  - hist0 and hist3 each in 400..600.
REQ-035 All-zero amplitudes, shots=50 -> miss=50, all hist = 0, sample_idx = 3 on every sample.
REQ-036 Saturation: CW=4, shots=20, amp00_re=16'h4000 -> hist0=15 (saturated), done after 25 edges.
REQ-037 Handshake:
  - start pulsed again during SAMPLE -> ignored, run completes unchanged;
  - shots=0 -> done 5 edges after start, all counts zero.
REQ-038 Reset pulse mid-SAMPLE -> all outputs 0 asynchronously, no done pulse; the next run reproduces the same sample sequence as the first run after reset.

Source files
------------

// File: rtl/measurement_sampler.sv
// Quantum measurement sampler: turns NS complex amplitudes into a cumulative
// probability table, then draws `shots` outcomes into per-state histograms.
module measurement_sampler #(
  parameter int          NQ   = 2,
  parameter int          AW   = 16,
  parameter int          CW   = 16,
  // Shot-count width; wider than CW lets a run push counters into saturation.
  parameter int          SW   = CW,
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [(2**NQ)*AW-1:0] amp_re,
  input  logic [(2**NQ)*AW-1:0] amp_im,
  input  logic                  start,
  input  logic [SW-1:0]         shots,
  output logic                  busy,
  output logic                  done,
  output logic [(2**NQ)*CW-1:0] hist,
  output logic [CW-1:0]         miss,
  output logic                  sample_valid,
  output logic [NQ-1:0]         sample_idx
);
  localparam int NS   = 2**NQ;
  localparam int PW   = 17;
  localparam int CUMW = PW + NQ;
  localparam int SH   = 2*(AW-2) - 16;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [SW-1:0] SHOT_ONE = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_e;

  function automatic logic [31:0] xorshift(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  state_e                  state_q, state_d;
  logic [NQ-1:0]           k_q, k_d;
  logic [SW-1:0]           rem_q, rem_d;
  logic [NS*AW-1:0]        re_q, re_d, im_q, im_d;
  logic [CUMW-1:0]         cum_q [NS];
  logic [CUMW-1:0]         cum_d [NS];
  logic [CW-1:0]           hist_q [NS];
  logic [CW-1:0]           hist_d [NS];
  logic [CW-1:0]           miss_q, miss_d;
  logic [31:0]             rng_q, rng_d;
  logic                    sv_q, sv_d;
  logic [NQ-1:0]           idx_q, idx_d;

  logic signed [AW-1:0]    re_k_s, im_k_s;
  logic signed [2*AW-1:0]  re_x_s, im_x_s, re_sq_s, im_sq_s;
  logic [2*AW:0]           pow_s;
  logic [PW-1:0]           p_s;
  logic [CUMW-1:0]         cum_prev_s, r_s;
  logic                    hit_s;
  logic [NQ-1:0]           sel_s;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD; else state_d = IDLE;
      LOAD:    if (k_q == '1) state_d = (rem_q == '0) ? DONE : SAMPLE; else state_d = LOAD;
      SAMPLE:  if (rem_q == SHOT_ONE) state_d = DONE; else state_d = SAMPLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      LOAD, SAMPLE: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      busy = 1'b0;
    endcase
  end

  // Probability of the state being loaded and outcome search for the current draw
  always_comb begin
    re_k_s     = re_q[k_q*AW +: AW];
    im_k_s     = im_q[k_q*AW +: AW];
    re_x_s     = (2*AW)'(re_k_s);
    im_x_s     = (2*AW)'(im_k_s);
    re_sq_s    = re_x_s * re_x_s;
    im_sq_s    = im_x_s * im_x_s;
    pow_s      = {1'b0, re_sq_s} + {1'b0, im_sq_s};
    p_s        = PW'(pow_s >> SH);
    cum_prev_s = (k_q == '0) ? '0 : cum_q[k_q - 1'b1];
    r_s        = CUMW'(rng_q[15:0]);
    hit_s      = 1'b0;
    sel_s      = '1;
    // Descending scan so the smallest matching index is the one that sticks
    for (int i = NS-1; i >= 0; i--) begin
      if (r_s < cum_q[i]) begin
        hit_s = 1'b1;
        sel_s = NQ'(i);
      end else begin
        hit_s = hit_s;
        sel_s = sel_s;
      end
    end
  end

  // Datapath next values
  always_comb begin
    k_d    = k_q;
    rem_d  = rem_q;
    re_d   = re_q;
    im_d   = im_q;
    cum_d  = cum_q;
    hist_d = hist_q;
    miss_d = miss_q;
    rng_d  = rng_q;
    sv_d   = 1'b0;
    idx_d  = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          re_d   = amp_re;
          im_d   = amp_im;
          rem_d  = shots;
          k_d    = '0;
          miss_d = '0;
          for (int i = 0; i < NS; i++) begin
            cum_d[i]  = '0;
            hist_d[i] = '0;
          end
        end else begin
          k_d = k_q;
        end
      end
      LOAD: begin
        cum_d[k_q] = cum_prev_s + CUMW'(p_s);
        k_d        = k_q + 1'b1;
      end
      SAMPLE: begin
        rng_d = xorshift(rng_q);
        rem_d = rem_q - SHOT_ONE;
        sv_d  = 1'b1;
        if (hit_s) begin
          hist_d[sel_s] = sat_inc(hist_q[sel_s]);
          idx_d         = sel_s;
        end else begin
          miss_d = sat_inc(miss_q);
          idx_d  = '1;
        end
      end
      default: sv_d = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q    <= '0;
      rem_q  <= '0;
      re_q   <= '0;
      im_q   <= '0;
      miss_q <= '0;
      rng_q  <= SEED_EFF;
      sv_q   <= 1'b0;
      idx_q  <= '0;
      for (int i = 0; i < NS; i++) begin
        cum_q[i]  <= '0;
        hist_q[i] <= '0;
      end
    end else begin
      k_q    <= k_d;
      rem_q  <= rem_d;
      re_q   <= re_d;
      im_q   <= im_d;
      miss_q <= miss_d;
      rng_q  <= rng_d;
      sv_q   <= sv_d;
      idx_q  <= idx_d;
      cum_q  <= cum_d;
      hist_q <= hist_d;
    end
  end

  // Flatten histogram counters onto the output bus
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      hist[i*CW +: CW] = hist_q[i];
    end
  end

  assign miss         = miss_q;
  assign sample_valid = sv_q;
  assign sample_idx   = idx_q;

endmodule

// File: tb/tb_measurement_sampler.sv
// Directed bench for measurement_sampler: basis, Bell, all-miss, handshake,
// saturation and mid-run reset, with an xorshift reference for the Bell draws.
module tb_measurement_sampler;
  localparam int NS = 4;
  localparam int AW = 16;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NS*AW-1:0] amp_re, amp_im;
  logic             start;
  logic [CW-1:0]    shots;
  logic             busy, done, sample_valid;
  logic [NS*CW-1:0] hist;
  logic [CW-1:0]    miss;
  logic [1:0]       sample_idx;

  logic [NS*AW-1:0] s_re, s_im;
  logic             s_start;
  logic [7:0]       s_shots;
  logic             s_busy, s_done, s_sv;
  logic [NS*4-1:0]  s_hist;
  logic [3:0]       s_miss;
  logic [1:0]       s_idx;

  int total = 0;
  int bad   = 0;
  int q_idx[$];
  int seq_a[$];
  int exp_seq[$];
  int e0, e3, em, lat, cyc_s, errs, seen_done;
  logic [31:0] x;

  localparam logic [NS*AW-1:0] BELL  = {16'h2D41, 16'h0000, 16'h0000, 16'h2D41};
  localparam logic [NS*AW-1:0] BASIS = {16'h0000, 16'h0000, 16'h0000, 16'h4000};

  measurement_sampler u_dut (
    .clk(clk), .reset(reset), .amp_re(amp_re), .amp_im(amp_im),
    .start(start), .shots(shots), .busy(busy), .done(done), .hist(hist),
    .miss(miss), .sample_valid(sample_valid), .sample_idx(sample_idx)
  );

  measurement_sampler #(.CW(4), .SW(8)) u_sat (
    .clk(clk), .reset(reset), .amp_re(s_re), .amp_im(s_im),
    .start(s_start), .shots(s_shots), .busy(s_busy), .done(s_done), .hist(s_hist),
    .miss(s_miss), .sample_valid(s_sv), .sample_idx(s_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] y;
    y = v ^ (v << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One run: start at a negedge, then watch at negedges; latency counts edges
  // from the accepting edge to the edge that samples done high.
  task automatic run(input logic [CW-1:0] n, input int chg_at, input int restart_at,
                     output int lat_o);
    int cyc;
    @(negedge clk); start = 1'b1; shots = n;
    @(posedge clk);
    @(negedge clk); start = 1'b0; shots = 16'd7;
    cyc = 0; lat_o = -1; q_idx.delete();
    while (cyc < 3000) begin
      if (cyc == chg_at) begin amp_re = '0; amp_im = {NS{16'h1234}}; end
      start = (cyc == restart_at);
      if (sample_valid) q_idx.push_back(int'(sample_idx));
      if (done) begin lat_o = cyc + 1; break; end
      @(posedge clk); cyc++; @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic int seq_diff(input int a[$], input int b[$]);
    int d = (a.size() == b.size()) ? 0 : 1;
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  initial begin
    // Reference draws for the Bell state: cum0 = 32766, cum3 = 65532
    x = 32'h1; e0 = 0; e3 = 0; em = 0;
    for (int i = 0; i < 1000; i++) begin
      if (x[15:0] < 16'd32766)      begin e0++; exp_seq.push_back(0); end
      else if (x[15:0] < 16'd65532) begin e3++; exp_seq.push_back(3); end
      else                          begin em++; exp_seq.push_back(3); end
      x = xs(x);
    end

    reset = 1'b1; start = 1'b0; shots = '0; amp_re = '0; amp_im = '0;
    s_start = 1'b0; s_shots = '0; s_re = BASIS; s_im = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hist", hist, 0);
    chk("rst_miss", miss, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_idx", sample_idx, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Bell state, first run after reset
    amp_re = BELL; amp_im = '0;
    run(16'd1000, -1, -1, lat);
    seq_a = q_idx;
    chk("bell_lat", lat, 1005);
    chk("bell_h1", hist[16 +: 16], 0);
    chk("bell_h2", hist[32 +: 16], 0);
    chk("bell_sum", hist[0 +: 16] + hist[48 +: 16] + miss, 1000);
    chk("bell_h0_range", (hist[0 +: 16] >= 400 && hist[0 +: 16] <= 600), 1);
    chk("bell_h3_range", (hist[48 +: 16] >= 400 && hist[48 +: 16] <= 600), 1);
    chk("bell_h0", hist[0 +: 16], e0);
    chk("bell_h3", hist[48 +: 16], e3);
    chk("bell_miss", miss, em);
    chk("bell_seq", seq_diff(q_idx, exp_seq), 0);

    // Basis state |00>
    amp_re = BASIS; amp_im = '0;
    run(16'd100, -1, -1, lat);
    chk("basis_lat", lat, 105);
    chk("basis_h0", hist[0 +: 16], 100);
    chk("basis_h123", hist[63:16], 0);
    chk("basis_miss", miss, 0);
    chk("basis_nvalid", q_idx.size(), 100);
    repeat (10) @(negedge clk);
    chk("hold_h0", hist[0 +: 16], 100);
    chk("hold_busy", busy, 0);

    // Amplitudes change right after acceptance and start re-pulsed mid-SAMPLE
    amp_re = BASIS; amp_im = '0;
    run(16'd100, 0, 50, lat);
    chk("hs_lat", lat, 105);
    chk("hs_h0", hist[0 +: 16], 100);
    chk("hs_h123", hist[63:16], 0);
    chk("hs_nvalid", q_idx.size(), 100);
    repeat (3) @(negedge clk);
    chk("hs_idle_after", busy, 0);
    amp_re = BASIS; amp_im = '0;

    // Zero shots
    run(16'd0, -1, -1, lat);
    chk("zero_lat", lat, 5);
    chk("zero_hist", hist, 0);
    chk("zero_miss", miss, 0);
    chk("zero_nvalid", q_idx.size(), 0);

    // All-zero amplitudes: every draw misses
    amp_re = '0; amp_im = '0;
    run(16'd50, -1, -1, lat);
    chk("miss_lat", lat, 55);
    chk("miss_cnt", miss, 50);
    chk("miss_hist", hist, 0);
    chk("miss_nvalid", q_idx.size(), 50);
    errs = 0;
    foreach (q_idx[i]) if (q_idx[i] != 3) errs++;
    chk("miss_idx", errs, 0);

    // Saturation on the 4-bit-counter instance
    @(negedge clk); s_start = 1'b1; s_shots = 8'd20;
    @(posedge clk);
    @(negedge clk); s_start = 1'b0;
    cyc_s = 0; lat = -1;
    while (cyc_s < 200) begin
      if (s_done) begin lat = cyc_s + 1; break; end
      @(posedge clk); cyc_s++; @(negedge clk);
    end
    chk("sat_lat", lat, 25);
    chk("sat_h0", s_hist[3:0], 15);
    chk("sat_h123", s_hist[15:4], 0);
    chk("sat_miss", s_miss, 0);

    // Reset in the middle of a Bell run
    amp_re = BELL; amp_im = '0;
    @(negedge clk); start = 1'b1; shots = 16'd1000;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    seen_done = 0;
    repeat (200) begin
      @(posedge clk); @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("mid_busy_before", busy, 1);
    chk("mid_hist_before_nz", (hist != '0), 1);
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_hist", hist, 0);
    chk("mid_miss", miss, 0);
    chk("mid_valid", sample_valid, 0);
    chk("mid_idx", sample_idx, 0);
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("mid_no_done", seen_done, 0);
    reset = 1'b1;
    run(16'd1000, -1, -1, lat);
    chk("rerun_lat", lat, 1005);
    chk("rerun_seq", seq_diff(q_idx, seq_a), 0);
    chk("rerun_h0", hist[0 +: 16], e0);
    chk("rerun_h3", hist[48 +: 16], e3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
